// File: rtl/radar_scan_sequencer.sv
// Radar scan scheduler: ping-pong servo sweep, one HC-SR04 trigger/echo measurement per slot,
// echo width converted to centimetres and reported as a single (pos, cm, timeout) result.
module radar_scan_sequencer #(
  parameter int N_POS       = 7,
  parameter int SETTLE_CYC  = 2700000,
  parameter int TRIG_CYC    = 270,
  parameter int RISE_TO_CYC = 675000,
  parameter int ECHO_TO_CYC = 675000,
  parameter int GAP_CYC     = 1620000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       echo,
  output logic       trig,
  output logic [2:0] servo_pos,
  output logic       sweep_dir,
  output logic       res_valid,
  output logic [2:0] res_pos,
  output logic [6:0] res_cm,
  output logic       res_to,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_MOVE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_CALC, S_REPORT, S_GAP
  } state_t;

  localparam logic [21:0] SETTLE_LAST = 22'(SETTLE_CYC - 1);
  localparam logic [21:0] TRIG_LAST   = 22'(TRIG_CYC - 1);
  localparam logic [21:0] RISE_LAST   = 22'(RISE_TO_CYC - 1);
  localparam logic [21:0] GAP_LAST    = 22'(GAP_CYC - 1);
  localparam logic [19:0] ECHO_LAST   = 20'(ECHO_TO_CYC - 1);
  localparam logic [2:0]  POS_LAST    = 3'(N_POS - 1);

  state_t      state, state_n;
  logic [21:0] cnt;
  logic [19:0] ecnt;
  logic        timeout;
  logic        echo_m, echo_s;
  logic [30:0] prod;
  logic [9:0]  cm_full;

  // ecnt * 1342 / 2^21 approximates cycles-at-27MHz to cm (speed of sound, round trip).
  assign prod    = 31'(ecnt) * 31'(1342);
  assign cm_full = 10'(prod >> 21);

  // res_valid is a one-cycle strobe with no ready: res_pos/res_cm/res_to are valid while
  // it is high and hold their value until the next strobe; the consumer must capture it.
  assign trig      = (state == S_TRIG);
  assign busy      = (state != S_IDLE);
  assign res_valid = (state == S_REPORT);

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:      if (run) state_n = S_MOVE;
      S_MOVE:      if (cnt == SETTLE_LAST) state_n = S_TRIG;
      S_TRIG:      if (cnt == TRIG_LAST) state_n = S_WAIT_RISE;
      S_WAIT_RISE: begin
        if (echo_s) state_n = S_MEASURE;
        else if (cnt == RISE_LAST) state_n = S_CALC;
      end
      S_MEASURE:   if (!echo_s || ecnt == ECHO_LAST) state_n = S_CALC;
      S_CALC:      state_n = S_REPORT;
      S_REPORT:    state_n = S_GAP;
      S_GAP:       if (cnt == GAP_LAST) state_n = run ? S_MOVE : S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ecnt      <= '0;
      timeout   <= 1'b0;
      echo_m    <= 1'b0;
      echo_s    <= 1'b0;
      servo_pos <= '0;
      sweep_dir <= 1'b0;
      res_pos   <= '0;
      res_cm    <= '0;
      res_to    <= 1'b0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      state  <= state_n;
      // One shared counter: restarts on every state change and stays at zero in IDLE.
      if (state_n != state || state_n == S_IDLE) cnt <= '0;
      else cnt <= cnt + 22'd1;

      case (state)
        S_TRIG: begin
          ecnt    <= '0;
          timeout <= 1'b0;
        end
        S_WAIT_RISE: begin
          if (echo_s) ecnt <= 20'd1;
          else if (cnt == RISE_LAST) timeout <= 1'b1;
        end
        S_MEASURE: begin
          if (echo_s) begin
            ecnt <= ecnt + 20'd1;
            if (ecnt == ECHO_LAST) timeout <= 1'b1;
          end
        end
        S_CALC: begin
          res_pos <= servo_pos;
          res_to  <= timeout;
          res_cm  <= (timeout || cm_full > 10'd127) ? 7'd127 : cm_full[6:0];
        end
        S_GAP: begin
          if (cnt == GAP_LAST && run) begin
            if (!sweep_dir) begin
              if (servo_pos < POS_LAST) servo_pos <= servo_pos + 3'd1;
              else begin
                sweep_dir <= 1'b1;
                servo_pos <= servo_pos - 3'd1;
              end
            end else begin
              if (servo_pos != 3'd0) servo_pos <= servo_pos - 3'd1;
              else begin
                sweep_dir <= 1'b0;
                servo_pos <= servo_pos + 3'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_radar_scan_sequencer.sv
// Directed bench for radar_scan_sequencer: results are scoreboarded through expected queues
// filled when echo stimulus is driven and drained whenever res_valid strobes.
module tb_radar_scan_sequencer;

  logic       clk, rst;
  logic       run, echo, trig, sweep_dir, res_valid, res_to, busy;
  logic [2:0] servo_pos, res_pos;
  logic [6:0] res_cm;
  logic       run_b, echo_b, trig_b, sweep_dir_b, res_valid_b, res_to_b, busy_b;
  logic [2:0] servo_pos_b, res_pos_b;
  logic [6:0] res_cm_b;

  logic [10:0] exp_q[$];
  logic [10:0] exp_qb[$];
  int total, bad, cyc, last_res_cyc;

  radar_scan_sequencer #(.N_POS(7), .SETTLE_CYC(4), .TRIG_CYC(3), .RISE_TO_CYC(20),
                         .ECHO_TO_CYC(4000), .GAP_CYC(2)) dut (
    .clk(clk), .rst(rst), .run(run), .echo(echo), .trig(trig), .servo_pos(servo_pos),
    .sweep_dir(sweep_dir), .res_valid(res_valid), .res_pos(res_pos), .res_cm(res_cm),
    .res_to(res_to), .busy(busy));

  radar_scan_sequencer #(.N_POS(7), .SETTLE_CYC(4), .TRIG_CYC(3), .RISE_TO_CYC(20),
                         .ECHO_TO_CYC(70000), .GAP_CYC(2)) dut_b (
    .clk(clk), .rst(rst), .run(run_b), .echo(echo_b), .trig(trig_b), .servo_pos(servo_pos_b),
    .sweep_dir(sweep_dir_b), .res_valid(res_valid_b), .res_pos(res_pos_b), .res_cm(res_cm_b),
    .res_to(res_to_b), .busy(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h required=%0h", tag, got, want);
    end
  endtask

  function automatic logic [6:0] cm_of(input int w);
    longint p;
    p = longint'(w) * 1342;
    p = p >> 21;
    return (p > 127) ? 7'd127 : 7'(p);
  endfunction

  // One clock; sample #1 after the edge and pop the scoreboard on any result strobe.
  task automatic tick();
    logic [10:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (res_valid) begin
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_res got=%0h required=none", {res_pos, res_cm, res_to});
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        last_res_cyc = cyc;
        check("res", 32'({res_pos, res_cm, res_to}), 32'(e));
      end
    end
    if (res_valid_b) begin
      total++;
      assert (exp_qb.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_res_b got=%0h required=none", {res_pos_b, res_cm_b, res_to_b});
      end
      if (exp_qb.size() > 0) begin
        e = exp_qb.pop_front();
        check("res_b", 32'({res_pos_b, res_cm_b, res_to_b}), 32'(e));
      end
    end
  endtask

  task automatic wait_trig_rise(input string tag, output int n);
    n = 0;
    while (trig !== 1'b1 && n < 300) begin tick(); n++; end
    check(tag, 32'(trig), 32'd1);
  endtask

  task automatic wait_trig_fall(input string tag, output int w);
    w = 0;
    while (trig === 1'b1 && w < 300) begin tick(); w++; end
    check(tag, 32'(trig), 32'd0);
  endtask

  task automatic wait_drain(input string tag, input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_qb.size() != 0) && n < max) begin tick(); n++; end
    check(tag, 32'(exp_q.size() + exp_qb.size()), 32'd0);
  endtask

  initial begin
    int p, d, n, w, fall_cyc;
    total = 0; bad = 0; cyc = 0; last_res_cyc = 0;
    rst = 1'b1; run = 1'b0; echo = 1'b0; run_b = 1'b0; echo_b = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_trig", 32'(trig), 32'd0);
    check("rst_pos", 32'(servo_pos), 32'd0);
    check("rst_dir", 32'(sweep_dir), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_res_pos", 32'(res_pos), 32'd0);
    check("rst_res_cm", 32'(res_cm), 32'd0);
    check("rst_res_to", 32'(res_to), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Fourteen slots of the ping-pong sweep; run drops during the last measurement.
    p = 0; d = 0;
    run = 1'b1;
    for (int s = 0; s < 14; s++) begin
      wait_trig_rise("trig_rise", n);
      if (s == 0) check("trig_latency", 32'(n), 32'd5);
      check("slot_pos", 32'(servo_pos), 32'(p));
      check("slot_dir", 32'(sweep_dir), 32'(d));
      w = (s == 0) ? 1562 : int'($urandom_range(50, 3200));
      exp_q.push_back({3'(p), cm_of(w), 1'b0});
      wait_trig_fall("trig_fall", n);
      if (s == 0) check("trig_width", 32'(n), 32'd3);
      echo = 1'b1;
      for (int k = 0; k < w; k++) begin
        tick();
        if (s == 13 && k == w / 2) run = 1'b0;
      end
      echo = 1'b0;
      wait_drain("slot_drain", 100);
      if (s < 13) begin
        if (d == 0) begin
          if (p < 6) p++; else begin d = 1; p--; end
        end else begin
          if (p > 0) p--; else begin d = 0; p++; end
        end
      end
    end
    repeat (20) tick();
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_pos", 32'(servo_pos), 32'(p));
    check("stop_trig", 32'(trig), 32'd0);

    // No echo at all: rise timeout.
    run = 1'b1;
    wait_trig_rise("trig_rise_nr", n);
    check("noecho_pos", 32'(servo_pos), 32'(p));
    exp_q.push_back({3'(p), 7'd127, 1'b1});
    wait_trig_fall("trig_fall_nr", n);
    fall_cyc = cyc;
    wait_drain("noecho_drain", 100);
    check("noecho_latency", 32'(last_res_cyc - fall_cyc), 32'd21);
    p++;

    // Echo stuck high: echo-width timeout.
    wait_trig_rise("trig_rise_st", n);
    exp_q.push_back({3'(p), 7'd127, 1'b1});
    wait_trig_fall("trig_fall_st", n);
    fall_cyc = cyc;
    echo = 1'b1;
    wait_drain("stuck_drain", 5000);
    check("stuck_latency", 32'(last_res_cyc - fall_cyc), 32'd4003);
    echo = 1'b0;
    p++;

    // Echo already high before WAIT_RISE counts as a rise; one synced cycle falls in TRIG.
    wait_trig_rise("trig_rise_hi", n);
    check("prehigh_pos", 32'(servo_pos), 32'(p));
    exp_q.push_back({3'(p), cm_of(1999), 1'b0});
    echo = 1'b1;
    repeat (2000) tick();
    echo = 1'b0;
    wait_drain("prehigh_drain", 100);
    p++;

    // Reset in the middle of TRIG.
    wait_trig_rise("trig_rise_r1", n);
    check("r1_pos_before", 32'(servo_pos), 32'(p));
    rst = 1'b1;
    tick();
    check("r1_trig", 32'(trig), 32'd0);
    check("r1_busy", 32'(busy), 32'd0);
    check("r1_pos", 32'(servo_pos), 32'd0);
    check("r1_valid", 32'(res_valid), 32'd0);
    run = 1'b0;
    rst = 1'b0;
    repeat (10) tick();

    // Reset in the middle of MEASURE.
    run = 1'b1;
    wait_trig_rise("trig_rise_r2", n);
    wait_trig_fall("trig_fall_r2", n);
    echo = 1'b1;
    repeat (20) tick();
    check("r2_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("r2_trig", 32'(trig), 32'd0);
    check("r2_busy", 32'(busy), 32'd0);
    check("r2_pos", 32'(servo_pos), 32'd0);
    check("r2_dir", 32'(sweep_dir), 32'd0);
    rst = 1'b0; run = 1'b0; echo = 1'b0;
    repeat (30) tick();
    check("r2_idle", 32'(busy), 32'd0);

    // Long echo on the wide-timeout instance: 15623 cycles -> 9 cm.
    run_b = 1'b1;
    exp_qb.push_back({3'd0, 7'd9, 1'b0});
    n = 0;
    while (trig_b !== 1'b1 && n < 300) begin tick(); n++; end
    check("b_trig_rise", 32'(trig_b), 32'd1);
    n = 0;
    while (trig_b === 1'b1 && n < 300) begin tick(); n++; end
    check("b_trig_fall", 32'(trig_b), 32'd0);
    echo_b = 1'b1;
    run_b = 1'b0;
    repeat (15623) tick();
    echo_b = 1'b0;
    wait_drain("b_drain", 100);
    repeat (20) tick();
    check("b_idle", 32'(busy_b), 32'd0);
    check("b_pos", 32'(servo_pos_b), 32'd0);
    check("b_dir", 32'(sweep_dir_b), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
